// File: rtl/i2s_rx_stereo.sv
// I2S receiver: oversamples async bclk/lrclk/sdata and deserialises each stereo frame into
// WIDTH-bit left-justified LEFT/RIGHT samples with a one-clock sample_valid pulse.
module i2s_rx_stereo #(
  parameter int unsigned WIDTH       = 18,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i2s_bclk,
  input  logic             i2s_lrclk,
  input  logic             i2s_sdata,
  output logic [WIDTH-1:0] LEFT,
  output logic [WIDTH-1:0] RIGHT,
  output logic             sample_valid,
  output logic             frame_err
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] WidthCnt = CntW'(WIDTH);
  localparam logic [5:0] IdleMax = 6'd63;

  typedef enum logic [1:0] {StIdle, StSkip, StShift, StHold} state_e;

  logic [SYNC_STAGES-1:0] bclk_sync, lrclk_sync, sdata_sync;
  logic                   bclk_prev, lr_prev;
  logic                   bclk_s, lr_s, sdata_s;
  logic                   tick, lr_edge, timeout;
  logic [5:0]             idle_cnt_q;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        bit_cnt_q, bit_cnt_d, bits_got;
  logic [WIDTH-1:0]       shreg_q, shreg_d, shreg_upd, bit_mask;
  logic                   side_q, side_d;
  logic [WIDTH-1:0]       left_hold_q, left_hold_d;
  logic [WIDTH-1:0]       left_d, right_d;
  logic                   valid_d, err_d;

  assign bclk_s  = bclk_sync[SYNC_STAGES-1];
  assign lr_s    = lrclk_sync[SYNC_STAGES-1];
  assign sdata_s = sdata_sync[SYNC_STAGES-1];
  assign tick    = bclk_s & ~bclk_prev;
  assign lr_edge = tick & (lr_s != lr_prev);
  assign timeout = tick & ~lr_edge & (idle_cnt_q == IdleMax);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    side_d      = side_q;
    left_hold_d = left_hold_q;
    left_d      = LEFT;
    right_d     = RIGHT;
    valid_d     = 1'b0;
    err_d       = 1'b0;

    // Bits land at their final MSB-first position, so a short slot is already left-justified.
    bit_mask  = {1'b1, {(WIDTH-1){1'b0}}} >> bit_cnt_q;
    shreg_upd = (state_q == StShift && sdata_s) ? (shreg_q | bit_mask) : shreg_q;
    bits_got  = (state_q == StShift) ? bit_cnt_q + 1'b1 : bit_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (lr_edge && !lr_s) begin
          state_d = StSkip;
          side_d  = 1'b0;
        end
      end
      // The lr_edge tick carried the previous slot's last bit; arm for the MSB before next tick.
      StSkip: begin
        state_d   = StShift;
        bit_cnt_d = '0;
        shreg_d   = '0;
      end
      StShift, StHold: begin
        if (lr_edge) begin
          err_d = (bits_got < WidthCnt);
          if (!side_q) begin
            left_hold_d = shreg_upd;
          end else begin
            left_d  = left_hold_q;
            right_d = shreg_upd;
            valid_d = 1'b1;
          end
          state_d   = StShift;
          bit_cnt_d = '0;
          shreg_d   = '0;
          side_d    = lr_s;
        end else if (timeout) begin
          state_d = StIdle;
        end else if (tick && state_q == StShift) begin
          shreg_d   = shreg_upd;
          bit_cnt_d = bits_got;
          if (bits_got == WidthCnt) state_d = StHold;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bclk_sync    <= '0;
      lrclk_sync   <= '0;
      sdata_sync   <= '0;
      bclk_prev    <= 1'b0;
      lr_prev      <= 1'b0;
      idle_cnt_q   <= '0;
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      side_q       <= 1'b0;
      left_hold_q  <= '0;
      LEFT         <= '0;
      RIGHT        <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      bclk_sync  <= {bclk_sync[SYNC_STAGES-2:0], i2s_bclk};
      lrclk_sync <= {lrclk_sync[SYNC_STAGES-2:0], i2s_lrclk};
      sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], i2s_sdata};
      bclk_prev  <= bclk_s;
      if (tick) begin
        lr_prev <= lr_s;
        if (lr_edge) begin
          idle_cnt_q <= '0;
        end else if (idle_cnt_q != IdleMax) begin
          idle_cnt_q <= idle_cnt_q + 1'b1;
        end
      end
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      side_q       <= side_d;
      left_hold_q  <= left_hold_d;
      LEFT         <= left_d;
      RIGHT        <= right_d;
      sample_valid <= valid_d;
      frame_err    <= err_d;
    end
  end

endmodule
